// File: rtl/iq_dac_stream_buffer.sv
// ---------------------------------------------------------------------------
// iq_dac_stream_buffer
//
// Downstream stage of the transmit IQ core. It takes interleaved I/Q beats
// (NUMBER_OF_LINE complex samples per beat, 16-bit signed words, even word =
// I, odd word = Q) and applies a separate unsigned Q2.14 gain to each rail.
// The gain uses round-half-up and saturation. The scaled beats are buffered
// in a first-word-fall-through FIFO and presented as an AXI-stream master.
//
// The upstream source ignores s_tready, so a refused beat is lost. Refused
// beats and output underrun cycles are each counted by a saturating counter.
//
// Ports
//   clock           sole clock, rising edge
//   resetn          asynchronous active-low reset, synchronous release
//   s_tvalid        input beat valid
//   s_tdata         input beat, 32*NUMBER_OF_LINE bits
//   s_tready        input accept
//   gain_i          Q2.14 gain for even (I) words, 0x4000 = 1.0
//   gain_q          Q2.14 gain for odd (Q) words
//   enable          admit new input beats
//   m_tvalid        output beat valid (FIFO not empty)
//   m_tdata         output beat (FIFO head, zero when empty)
//   m_tready        downstream accept
//   fifo_level      entries currently held in the FIFO
//   drop_count      saturating count of refused beats
//   underflow_count saturating count of output underrun cycles
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. Once valid is raised, the master side holds the
// beat stable until that edge. s_tvalid is the exception: upstream never
// waits, so any beat seen while s_tready is low is dropped.
// ---------------------------------------------------------------------------
module iq_dac_stream_buffer #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          s_tvalid,
  input  logic [32*NUMBER_OF_LINE-1:0]  s_tdata,
  output logic                          s_tready,
  input  logic [15:0]                   gain_i,
  input  logic [15:0]                   gain_q,
  input  logic                          enable,
  output logic                          m_tvalid,
  output logic [32*NUMBER_OF_LINE-1:0]  m_tdata,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   underflow_count
);

  localparam int NW = 2 * NUMBER_OF_LINE;
  localparam int W  = 32 * NUMBER_OF_LINE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW:0] DEPTH_V = (LW+1)'(FIFO_DEPTH);

  // signed16 x unsigned16. Both operands are widened to 33 bits, so the
  // true product (at most about 2^31 in magnitude) is exact.
  function automatic logic signed [32:0] mul_word(input logic [15:0] x,
                                                  input logic [15:0] g);
    logic signed [32:0] a;
    logic signed [32:0] b;
    a = {{17{x[15]}}, x};
    b = {17'b0, g};
    return a * b;
  endfunction

  // Round half up (+2^13, then arithmetic shift by 14). Clamp to int16.
  function automatic logic [15:0] round_sat(input logic signed [32:0] p);
    logic signed [32:0] r;
    r = (p + 33'sd8192) >>> 14;
    if (r > 33'sd32767)       return 16'h7FFF;
    else if (r < -33'sd32768) return 16'h8000;
    else                      return r[15:0];
  endfunction

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  logic          arm_q;          // set one edge after reset release
  logic          valid1_q;
  logic          valid2_q;
  logic          primed_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   uf_q, uf_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic [LW:0]   occupancy;

  // FIFO entries plus beats still in the two-stage gain pipeline. Admission
  // keeps this sum within the FIFO depth, so a push is always accepted.
  always_comb begin
    occupancy = {1'b0, level_q} + {{LW{1'b0}}, valid1_q}
              + {{LW{1'b0}}, valid2_q};
  end

  assign s_tready = enable && arm_q && (occupancy < DEPTH_V);
  assign accept   = s_tvalid && s_tready;
  assign push     = valid2_q;
  assign m_tvalid = (level_q != '0);
  assign pop      = m_tvalid && m_tready;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    drop_d = drop_q;
    if (s_tvalid && enable && !s_tready && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_comb begin
    uf_d = uf_q;
    if (primed_q && m_tready && !m_tvalid && (uf_q != 16'hFFFF))
      uf_d = uf_q + 16'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arm_q    <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      primed_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      uf_q     <= '0;
    end else begin
      arm_q    <= 1'b1;
      valid1_q <= accept;
      valid2_q <= valid1_q;
      // Underrun counting starts at the first write after enable goes high.
      if (!enable)   primed_q <= 1'b0;
      else if (push) primed_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      drop_q   <= drop_d;
      uf_q     <= uf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Gain datapath. Data registers carry no reset: the valid bits qualify
  // them. Gains are multiplied in on the accept edge, so each beat is scaled
  // by the gain that was present when that beat was accepted.
  // -------------------------------------------------------------------------
  logic signed [32:0] prod1_d [NW];
  logic signed [32:0] prod1_q [NW];
  logic [W-1:0]       data2_d;
  logic [W-1:0]       data2_q;

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      prod1_d[w] = mul_word(s_tdata[16*w +: 16], (w % 2 == 1) ? gain_q : gain_i);
    end
  end

  always_comb begin
    data2_d = '0;
    for (int w = 0; w < NW; w++) begin
      data2_d[16*w +: 16] = round_sat(prod1_q[w]);
    end
  end

  always_ff @(posedge clock) begin
    if (accept)   prod1_q <= prod1_d;
    if (valid1_q) data2_q <= data2_d;
  end

  // -------------------------------------------------------------------------
  // FWFT storage. Pointers wrap naturally because the depth is a power of
  // two. The head is masked when the FIFO is empty, so a reset shows zero
  // data at once.
  // -------------------------------------------------------------------------
  logic [W-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data2_q;
  end

  assign m_tdata         = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level      = level_q;
  assign drop_count      = drop_q;
  assign underflow_count = uf_q;

endmodule

// File: tb/tb_iq_dac_stream_buffer.sv
module tb_iq_dac_stream_buffer;

  localparam int N  = 8;
  localparam int W  = 32 * N;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  // clock / reset
  logic          clock = 1'b0;
  logic          resetn;
  logic          s_tvalid;
  logic [W-1:0]  s_tdata;
  logic          s_tready;
  logic [15:0]   gain_i, gain_q;
  logic          enable;
  logic          m_tvalid;
  logic [W-1:0]  m_tdata;
  logic          m_tready;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_count, underflow_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  iq_dac_stream_buffer #(.NUMBER_OF_LINE(N), .FIFO_DEPTH(D)) dut (
    .clock(clock), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .gain_i(gain_i), .gain_q(gain_q), .enable(enable),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
    .fifo_level(fifo_level), .drop_count(drop_count),
    .underflow_count(underflow_count)
  );

  // Beat t holds the words t*16 + 0 .. t*16 + 15.
  function automatic logic [W-1:0] ramp(input int t);
    logic [W-1:0] b;
    b = '0;
    for (int w = 0; w < 2*N; w++) b[16*w +: 16] = 16'(t*2*N + w);
    return b;
  endfunction

  // Step one edge. Inputs are driven, and outputs are sampled, 1 ns after
  // the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    s_tvalid = 1'b0;
    resetn   = 1'b0;
    #2;
    resetn   = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; s_tvalid = 1'b0; s_tdata = ramp(0);
    gain_i = 16'h4000; gain_q = 16'h4000; m_tready = 1'b1;
    #3;
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL rst_m_tdata: got %h expected 0", m_tdata); end
    vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
    vectors++; if (underflow_count !== 16'd0) begin miscompares++; $display("FAIL rst_uf: got %0d expected 0", underflow_count); end
    resetn = 1'b1;
    #1;
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_before_edge: got %b expected 0", s_tready); end
    tick();
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after_edge: got %b expected 1", s_tready); end
    enable = 1'b0;
    #1;
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL ready_enable_low: got %b expected 0", s_tready); end
  endtask

  task automatic test_passthrough();
    reset_dut();
    enable = 1'b1; m_tready = 1'b1; gain_i = 16'h4000; gain_q = 16'h4000;
    s_tvalid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      s_tdata = ramp(t);
      #1;
      vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL pt_ready t=%0d: got %b expected 1", t, s_tready); end
      tick();
      if (t >= 2) begin
        vectors++; if (m_tvalid !== 1'b1 || m_tdata !== ramp(t-2)) begin miscompares++; $display("FAIL pt_data t=%0d: got v=%b %h expected %h", t, m_tvalid, m_tdata, ramp(t-2)); end
        vectors++; if (fifo_level !== 5'd1) begin miscompares++; $display("FAIL pt_level t=%0d: got %0d expected 1", t, fifo_level); end
      end else begin
        vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL pt_latency t=%0d: got %b expected 0", t, m_tvalid); end
      end
    end
    vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL pt_drop: got %0d expected 0", drop_count); end
    vectors++; if (underflow_count !== 16'd0) begin miscompares++; $display("FAIL pt_uf: got %0d expected 0", underflow_count); end
    s_tvalid = 1'b0;
    for (int t = 10; t < 12; t++) begin
      tick();
      vectors++; if (m_tvalid !== 1'b1 || m_tdata !== ramp(t)) begin miscompares++; $display("FAIL pt_tail t=%0d: got %h expected %h", t, m_tdata, ramp(t)); end
    end
    tick();
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL pt_empty: got %b expected 0", m_tvalid); end
  endtask

  task automatic test_round_sat();
    logic [W-1:0] b;
    reset_dut();
    enable = 1'b1; m_tready = 1'b1; s_tvalid = 1'b1;
    b = '0;
    b[15:0] = 16'd3; b[31:16] = 16'd1000; b[47:32] = 16'hFFFD; b[63:48] = 16'hB1E0;
    gain_i = 16'h2000; gain_q = 16'hC000; s_tdata = b;
    tick();
    b = '0;
    b[15:0] = 16'h7FFF; b[47:32] = 16'h8000;
    gain_i = 16'h8000; s_tdata = b;
    tick();
    s_tvalid = 1'b0;
    tick();
    vectors++; if (m_tdata[15:0] !== 16'd2) begin miscompares++; $display("FAIL rs_i_pos3: got %h expected 0002", m_tdata[15:0]); end
    vectors++; if (m_tdata[31:16] !== 16'h0BB8) begin miscompares++; $display("FAIL rs_q_1000: got %h expected 0bb8", m_tdata[31:16]); end
    vectors++; if (m_tdata[47:32] !== 16'hFFFF) begin miscompares++; $display("FAIL rs_i_neg3: got %h expected ffff", m_tdata[47:32]); end
    vectors++; if (m_tdata[63:48] !== 16'h8000) begin miscompares++; $display("FAIL rs_q_sat_neg: got %h expected 8000", m_tdata[63:48]); end
    vectors++; if (m_tdata[W-1:64] !== '0) begin miscompares++; $display("FAIL rs_zero_words_a: got %h expected 0", m_tdata[W-1:64]); end
    tick();
    vectors++; if (m_tdata[15:0] !== 16'h7FFF) begin miscompares++; $display("FAIL rs_i_sat_pos: got %h expected 7fff", m_tdata[15:0]); end
    vectors++; if (m_tdata[47:32] !== 16'h8000) begin miscompares++; $display("FAIL rs_i_sat_min: got %h expected 8000", m_tdata[47:32]); end
    vectors++; if (m_tdata[31:16] !== 16'h0000 || m_tdata[W-1:48] !== '0) begin miscompares++; $display("FAIL rs_zero_words_b: got %h expected zero words", m_tdata); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    enable = 1'b1; m_tready = 1'b0; gain_i = 16'h4000; gain_q = 16'h4000;
    s_tvalid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      s_tdata = ramp(t);
      #1;
      vectors++; if (s_tready !== (t < 16)) begin miscompares++; $display("FAIL bp_ready t=%0d: got %b expected %b", t, s_tready, (t < 16)); end
      tick();
    end
    s_tvalid = 1'b0;
    vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL bp_level: got %0d expected 16", fifo_level); end
    vectors++; if (drop_count !== 16'd24) begin miscompares++; $display("FAIL bp_drop: got %0d expected 24", drop_count); end
    m_tready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      vectors++; if (m_tvalid !== 1'b1 || m_tdata !== ramp(t)) begin miscompares++; $display("FAIL bp_drain t=%0d: got v=%b %h expected %h", t, m_tvalid, m_tdata, ramp(t)); end
      tick();
    end
    vectors++; if (m_tvalid !== 1'b0 || fifo_level !== '0) begin miscompares++; $display("FAIL bp_empty: got v=%b level=%0d expected 0/0", m_tvalid, fifo_level); end
  endtask

  task automatic test_underflow();
    reset_dut();
    enable = 1'b1; m_tready = 1'b1; gain_i = 16'h4000; gain_q = 16'h4000;
    s_tvalid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      s_tdata = ramp(t);
      tick();
    end
    s_tvalid = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    s_tvalid = 1'b1; s_tdata = ramp(50);
    for (int t = 0; t < 4; t++) tick();
    vectors++; if (underflow_count !== 16'd5) begin miscompares++; $display("FAIL uf_count: got %0d expected 5", underflow_count); end
    enable = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL uf_drained: got %b expected 0", m_tvalid); end
    vectors++; if (underflow_count !== 16'd5) begin miscompares++; $display("FAIL uf_hold_disabled: got %0d expected 5", underflow_count); end
    vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL uf_no_drop_disabled: got %0d expected 0", drop_count); end
    s_tvalid = 1'b0;
  endtask

  task automatic test_gain_change();
    logic [W-1:0] e0, e1;
    reset_dut();
    enable = 1'b1; m_tready = 1'b1; gain_q = 16'h4000;
    for (int w = 0; w < 2*N; w++) begin
      e0[16*w +: 16] = 16'h0100;
      e1[16*w +: 16] = (w % 2 == 1) ? 16'h0100 : 16'h0080;
    end
    s_tvalid = 1'b1; s_tdata = e0;
    gain_i = 16'h4000;
    tick();
    gain_i = 16'h2000;
    tick();
    s_tvalid = 1'b0;
    tick();
    vectors++; if (m_tdata !== e0) begin miscompares++; $display("FAIL gc_first: got %h expected %h", m_tdata, e0); end
    tick();
    vectors++; if (m_tdata !== e1) begin miscompares++; $display("FAIL gc_second: got %h expected %h", m_tdata, e1); end
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    enable = 1'b1; m_tready = 1'b0; gain_i = 16'h4000; gain_q = 16'h4000;
    s_tvalid = 1'b1;
    for (int t = 0; t < 7; t++) begin
      s_tdata = ramp(t);
      tick();
    end
    s_tvalid = 1'b0;
    tick(); tick();
    vectors++; if (fifo_level !== 5'd7) begin miscompares++; $display("FAIL rm_level_before: got %0d expected 7", fifo_level); end
    resetn = 1'b0;
    #1;
    vectors++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || fifo_level !== '0) begin miscompares++; $display("FAIL rm_async_fifo: got v=%b level=%0d data=%h expected zeros", m_tvalid, fifo_level, m_tdata); end
    vectors++; if (s_tready !== 1'b0 || drop_count !== 16'd0 || underflow_count !== 16'd0) begin miscompares++; $display("FAIL rm_async_ctrl: got rdy=%b drop=%0d uf=%0d expected zeros", s_tready, drop_count, underflow_count); end
    #1;
    resetn = 1'b1;
    tick();
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = ramp(100);
    tick();
    s_tvalid = 1'b0;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rm_no_stale_1: got %b expected 0", m_tvalid); end
    tick();
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rm_no_stale_2: got %b expected 0", m_tvalid); end
    tick();
    vectors++; if (m_tvalid !== 1'b1 || m_tdata !== ramp(100) || fifo_level !== 5'd1) begin miscompares++; $display("FAIL rm_first_beat: got v=%b level=%0d %h expected %h", m_tvalid, fifo_level, m_tdata, ramp(100)); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_round_sat();
    test_backpressure();
    test_underflow();
    test_gain_change();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
